// File: rtl/game_pkg.sv
// Shared game constants and state encoding, reused by the invaders block and renderer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WON  = 2'b10,
    ST_LOST = 2'b11
  } game_state_t;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 16;
  localparam int X_W       = 5;
  localparam int Y_W       = 4;

  localparam logic [Y_W-1:0] PARK_Y = '0;
  localparam logic [X_W-1:0] PARK_X = '0;
  localparam logic [X_W-1:0] MAX_X  = X_W'(GRID_COLS - 1);
  localparam logic [Y_W-1:0] MAX_Y  = Y_W'(GRID_ROWS - 1);

  // Player column can arrive out of range; keep the bullet on the grid.
  function automatic logic [X_W-1:0] clamp_col(input logic [X_W-1:0] x);
    return (x > MAX_X) ? MAX_X : x;
  endfunction

endpackage

// File: rtl/game_edge_detect.sv
// Registered rising-edge detector: history flop plus combinational rise = level & ~history.
module game_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/game_ctrl.sv
// Space Invaders game sequencer and single player-bullet scheduler.
// Optional build macro: GAME_CTRL_AUTOFIRE_EN (launch on fire level instead of fire edge).
module game_ctrl
  import game_pkg::*;
#(
  parameter int BULLET_PERIOD = 100000,
  parameter int NUM_INVADERS  = 9,
  parameter int LOSE_ROW      = 14,
  parameter int LAUNCH_ROW    = 14
) (
  input  logic           i_clk_25MHz,
  input  logic           i_reset_n,
  input  logic           i_start,
  input  logic           i_fire,
  input  logic [X_W-1:0] i_player_x,
  input  logic           i_hit,
  input  logic [Y_W-1:0] i_invaders_row,
  output logic           o_invaders_reset,
  output logic [X_W-1:0] o_bullet_x,
  output logic [Y_W-1:0] o_bullet_y,
  output logic           o_bullet_active,
  output logic [7:0]     o_score,
  output logic [1:0]     o_state
);

  localparam int CNT_W = (BULLET_PERIOD > 2) ? $clog2(BULLET_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BULLET_PERIOD - 1);
  localparam logic [Y_W-1:0]   LAUNCH_Y = Y_W'(LAUNCH_ROW);
  localparam logic [Y_W-1:0]   LOSE_Y   = Y_W'(LOSE_ROW);
  localparam logic [3:0]       WIN_HITS = 4'(NUM_INVADERS);

  game_state_t     state, state_next;
  logic            inv_reset, inv_reset_next;
  logic [X_W-1:0]  bullet_x, bullet_x_next;
  logic [Y_W-1:0]  bullet_y, bullet_y_next;
  logic            bullet_active, bullet_active_next;
  logic [CNT_W-1:0] step_cnt, step_cnt_next;
  logic [7:0]      score, score_next;
  logic [3:0]      hit_cnt, hit_cnt_next;

  logic start_edge, fire_edge;
  logic hit_ok, win, lose, launch_req, new_game;

  game_edge_detect u_start_edge (
    .clk   (i_clk_25MHz),
    .rst_n (i_reset_n),
    .level (i_start),
    .rise  (start_edge)
  );

  game_edge_detect u_fire_edge (
    .clk   (i_clk_25MHz),
    .rst_n (i_reset_n),
    .level (i_fire),
    .rise  (fire_edge)
  );

`ifdef GAME_CTRL_AUTOFIRE_EN
  assign launch_req = i_fire | fire_edge;
`else
  assign launch_req = fire_edge;
`endif

  assign hit_ok   = i_hit & bullet_active & (state == ST_PLAY);
  assign win      = hit_ok & ((hit_cnt + 4'd1) == WIN_HITS);
  assign lose     = (i_invaders_row >= LOSE_Y);
  assign new_game = (state == ST_IDLE) & start_edge;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_edge) state_next = ST_PLAY;
      ST_PLAY: begin
        // A winning hit and a landing invader in the same cycle resolve as a win.
        if (win)       state_next = ST_WON;
        else if (lose) state_next = ST_LOST;
      end
      ST_WON:  if (start_edge) state_next = ST_IDLE;
      ST_LOST: if (start_edge) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bullet_x_next      = PARK_X;
    bullet_y_next      = PARK_Y;
    bullet_active_next = 1'b0;
    step_cnt_next      = '0;
    if ((state == ST_PLAY) && (state_next == ST_PLAY)) begin
      if (bullet_active) begin
        if (hit_ok) begin
          bullet_active_next = 1'b0;
        end else if (step_cnt == CNT_LAST) begin
          // Stepping off row 1 leaves the bullet parked rather than at row 0 active.
          if (bullet_y != 4'd1) begin
            bullet_x_next      = bullet_x;
            bullet_y_next      = bullet_y - 4'd1;
            bullet_active_next = 1'b1;
          end
        end else begin
          bullet_x_next      = bullet_x;
          bullet_y_next      = bullet_y;
          bullet_active_next = 1'b1;
          step_cnt_next      = step_cnt + 1'b1;
        end
      end else if (launch_req) begin
        bullet_x_next      = clamp_col(i_player_x);
        bullet_y_next      = LAUNCH_Y;
        bullet_active_next = 1'b1;
      end
    end
  end

  always_comb begin
    score_next     = score;
    hit_cnt_next   = hit_cnt;
    inv_reset_next = (state_next == ST_IDLE);
    if (new_game) begin
      score_next   = 8'd0;
      hit_cnt_next = 4'd0;
    end else if (hit_ok) begin
      score_next   = (score == 8'hFF) ? score : score + 8'd1;
      hit_cnt_next = hit_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      inv_reset     <= 1'b1;
      bullet_x      <= PARK_X;
      bullet_y      <= PARK_Y;
      bullet_active <= 1'b0;
      step_cnt      <= '0;
      score         <= 8'd0;
      hit_cnt       <= 4'd0;
    end else begin
      state         <= state_next;
      inv_reset     <= inv_reset_next;
      bullet_x      <= bullet_x_next;
      bullet_y      <= bullet_y_next;
      bullet_active <= bullet_active_next;
      step_cnt      <= step_cnt_next;
      score         <= score_next;
      hit_cnt       <= hit_cnt_next;
    end
  end

  assign o_invaders_reset = inv_reset;
  assign o_bullet_x       = bullet_x;
  assign o_bullet_y       = bullet_y;
  assign o_bullet_active  = bullet_active;
  assign o_score          = score;
  assign o_state          = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Scenario bench for game_ctrl with a four-cycle bullet step.
module tb_game_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, fire, hit;
  logic [4:0] player_x;
  logic [3:0] inv_row;
  logic       inv_reset;
  logic [4:0] bullet_x;
  logic [3:0] bullet_y;
  logic       bullet_active;
  logic [7:0] score;
  logic [1:0] state;

  logic [20:0] exp_q[$];
  logic [20:0] got, e;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  game_ctrl #(.BULLET_PERIOD(4)) dut (
    .i_clk_25MHz      (clk),
    .i_reset_n        (rst_n),
    .i_start          (start),
    .i_fire           (fire),
    .i_player_x       (player_x),
    .i_hit            (hit),
    .i_invaders_row   (inv_row),
    .o_invaders_reset (inv_reset),
    .o_bullet_x       (bullet_x),
    .o_bullet_y       (bullet_y),
    .o_bullet_active  (bullet_active),
    .o_score          (score),
    .o_state          (state)
  );

  function automatic logic [20:0] mk(input logic [1:0] st, input logic r, input logic [4:0] x,
                                     input logic [3:0] y, input logic a, input logic [7:0] s);
    return {st, r, x, y, a, s};
  endfunction

  function automatic logic [20:0] snap();
    return {state, inv_reset, bullet_x, bullet_y, bullet_active, score};
  endfunction

  function automatic string fmt(input logic [20:0] v);
    return $sformatf("st=%0d rst=%0b x=%0d y=%0d act=%0b score=%0d",
                     v[20:19], v[18], v[17:13], v[12:9], v[8], v[7:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; fire = 0; hit = 0; player_x = 0; inv_row = 0;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL reset_hold: got %s, need %s", fmt(got), fmt(e)); else passed++;
    rst_n = 1'b1;
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL reset_release: got %s, need %s", fmt(got), fmt(e)); else passed++;
  endtask

  task automatic test_launch_flight();
    start = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL idle_to_play: got %s, need %s", fmt(got), fmt(e)); else passed++;
    start = 1'b0;
    player_x = 5'd7; fire = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 7, 14, 1, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL launch: got %s, need %s", fmt(got), fmt(e)); else passed++;
    fire = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      int n;
      logic [3:0] ey;
      n = k / 4;
      ey = 4'(14 - n);
      if (n >= 14) exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
      else         exp_q.push_back(mk(ST_PLAY, 0, 7, ey, 1, 0));
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL flight k=%0d: got %s, need %s", k, fmt(got), fmt(e)); else passed++;
    end
  endtask

  task automatic test_clamp_and_drop();
    player_x = 5'd25; fire = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 19, 14, 1, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL clamp_launch: got %s, need %s", fmt(got), fmt(e)); else passed++;
    fire = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin fire = 1'b1; player_x = 5'd3; end
      if (k == 3) fire = 1'b0;
      exp_q.push_back(mk(ST_PLAY, 0, 19, (k >= 4) ? 4'd13 : 4'd14, 1, 0));
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL fire_dropped k=%0d: got %s, need %s", k, fmt(got), fmt(e)); else passed++;
    end
  endtask

  task automatic test_hit();
    hit = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 1));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL hit_over_step: got %s, need %s", fmt(got), fmt(e)); else passed++;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 1));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL hit_inactive: got %s, need %s", fmt(got), fmt(e)); else passed++;
    hit = 1'b0;
  endtask

  task automatic test_win_lose();
    for (int i = 2; i <= 9; i++) begin
      logic [4:0] px;
      px = 5'($urandom_range(0, 19));
      player_x = px; fire = 1'b1;
      exp_q.push_back(mk(ST_PLAY, 0, px, 14, 1, 8'(i - 1)));
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL win_launch i=%0d: got %s, need %s", i, fmt(got), fmt(e)); else passed++;
      fire = 1'b0; hit = 1'b1;
      if (i == 9) exp_q.push_back(mk(ST_WON, 0, 0, 0, 0, 9));
      else        exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 8'(i)));
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL win_hit i=%0d: got %s, need %s", i, fmt(got), fmt(e)); else passed++;
      hit = 1'b0;
    end
    hit = 1'b1; fire = 1'b1;
    exp_q.push_back(mk(ST_WON, 0, 0, 0, 0, 9));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL won_ignores_inputs: got %s, need %s", fmt(got), fmt(e)); else passed++;
    hit = 1'b0; fire = 1'b0;
    start = 1'b1;
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 9));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL won_to_idle: got %s, need %s", fmt(got), fmt(e)); else passed++;
    start = 1'b0;
    tick();
    start = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL replay_clears_score: got %s, need %s", fmt(got), fmt(e)); else passed++;
    start = 1'b0;
    inv_row = 4'd13;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL row13_no_lose: got %s, need %s", fmt(got), fmt(e)); else passed++;
    player_x = 5'd4; fire = 1'b1;
    exp_q.push_back(mk(ST_PLAY, 0, 4, 14, 1, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL pre_lose_launch: got %s, need %s", fmt(got), fmt(e)); else passed++;
    fire = 1'b0; inv_row = 4'd14;
    exp_q.push_back(mk(ST_LOST, 0, 0, 0, 0, 0));
    tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL lose_parks: got %s, need %s", fmt(got), fmt(e)); else passed++;
    inv_row = 4'd0;
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    pulse_start();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL lost_to_idle: got %s, need %s", fmt(got), fmt(e)); else passed++;
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
    pulse_start();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL lost_replay: got %s, need %s", fmt(got), fmt(e)); else passed++;
    for (int i = 1; i <= 9; i++) begin
      player_x = 5'd10; fire = 1'b1;
      tick();
      fire = 1'b0; hit = 1'b1;
      if (i == 9) inv_row = 4'd14;
      if (i == 9) exp_q.push_back(mk(ST_WON, 0, 0, 0, 0, 9));
      else        exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 8'(i)));
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL win_lose_tie i=%0d: got %s, need %s", i, fmt(got), fmt(e)); else passed++;
      hit = 1'b0;
    end
    inv_row = 4'd0;
    pulse_start();
    exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 0));
    pulse_start();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL tie_replay: got %s, need %s", fmt(got), fmt(e)); else passed++;
  endtask

  task automatic test_fire_held();
    player_x = 5'd11; fire = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 2) hit = 1'b1;
      if (k == 3) hit = 1'b0;
      if (k == 1)      exp_q.push_back(mk(ST_PLAY, 0, 11, 14, 1, 0));
      else if (k == 2) exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 1));
      else begin
`ifdef GAME_CTRL_AUTOFIRE_EN
        exp_q.push_back(mk(ST_PLAY, 0, 11, 4'(14 - (k - 3) / 4), 1, 1));
`else
        exp_q.push_back(mk(ST_PLAY, 0, 0, 0, 0, 1));
`endif
      end
      tick();
      got = snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL fire_held k=%0d: got %s, need %s", k, fmt(got), fmt(e)); else passed++;
    end
    fire = 1'b0;
    // Let any autofire bullet finish so the next scenario starts parked.
    repeat (60) tick();
  endtask

  task automatic test_reset_mid();
    player_x = 5'd6; fire = 1'b1;
    tick();
    fire = 1'b0;
    exp_q.push_back(mk(ST_PLAY, 0, 6, 9, 1, 1));
    repeat (20) tick();
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL pre_reset_y9: got %s, need %s", fmt(got), fmt(e)); else passed++;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    #1;
    got = snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL reset_async: got %s, need %s", fmt(got), fmt(e)); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_launch_flight();
    test_clamp_and_drop();
    test_hit();
    test_win_lose();
    test_fire_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
